// File: rtl/mux_pkg.sv
// Shared types and default sizing for the N-to-1 registered mux and the
// pipeline stages that feed it.
package mux_pkg;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mux_mode_t;

  localparam int MUX_WIDTH = 32;
  localparam int MUX_N     = 4;

  // Next round-robin start position after channel idx was served.
  function automatic int rr_next(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found when
// searching cyclically upward from i_ptr. The pointer itself lives outside.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [SEL_W-1:0] i_ptr,
  input  logic             i_enable,
  output logic [N-1:0]     o_grant,
  output logic [SEL_W-1:0] o_grant_idx
);

  logic             w_found;
  logic [SEL_W-1:0] w_idx;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_idx       = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = SEL_W'((int'(i_ptr) + k) % N);
      if (i_enable && !w_found && i_req[w_idx]) begin
        w_found          = 1'b1;
        o_grant[w_idx]   = 1'b1;
        o_grant_idx      = w_idx;
      end
    end
  end

endmodule

// File: rtl/mux_nto1_reg.sv
// N-to-1 mux with a single registered output slot and valid/ready handshake;
// channel chosen by explicit select or by round-robin over valid requesters.
module mux_nto1_reg
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_WIDTH,
  parameter int N     = MUX_N,
  parameter int SEL_W = $clog2(N)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N-1:0][WIDTH-1:0]   in_data,
  input  logic [N-1:0]              in_valid,
  output logic [N-1:0]              in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      flush,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_src,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [WIDTH-1:0] r_data;
  logic [SEL_W-1:0] r_src;
  logic             r_valid;
  logic [SEL_W-1:0] r_ptr;

  mux_mode_t        w_mode;
  logic             w_can_load;
  logic             w_sel_ok;
  logic [N-1:0]     w_rr_grant;
  logic [SEL_W-1:0] w_rr_idx;
  logic [SEL_W-1:0] w_chosen_idx;
  logic [N-1:0]     w_take;
  logic             w_xfer;
  logic [WIDTH-1:0] w_load_data;

  assign w_mode     = mux_mode_t'(mode);
  assign w_can_load = !flush && (!r_valid || out_ready);
  assign w_sel_ok   = (int'(sel) < N);

  rr_arbiter #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_arb (
    .i_req       (in_valid),
    .i_ptr       (r_ptr),
    .i_enable    (w_mode == MODE_RR),
    .o_grant     (w_rr_grant),
    .o_grant_idx (w_rr_idx)
  );

  assign w_chosen_idx = (w_mode == MODE_RR) ? w_rr_idx : sel;

  // Ready is derived only from control inputs, never from in_data.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ready
      always_comb begin
        if (w_mode == MODE_RR) begin
          in_ready[gi] = w_can_load && w_rr_grant[gi];
        end else begin
          in_ready[gi] = w_can_load && w_sel_ok && (sel == SEL_W'(gi));
        end
      end
    end
  endgenerate

  assign w_take = in_valid & in_ready;
  assign w_xfer = |w_take;

  // At most one w_take bit is set, so an AND-OR mux suffices.
  always_comb begin
    w_load_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_take[i]) begin
        w_load_data = w_load_data | in_data[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_src   <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_xfer) begin
        r_data  <= w_load_data;
        r_src   <= w_chosen_idx;
        r_valid <= 1'b1;
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end
      if (w_xfer && (w_mode == MODE_RR)) begin
        r_ptr <= SEL_W'(rr_next(int'(w_rr_idx), N));
      end
    end
  end

  assign out_data  = r_data;
  assign out_src   = r_src;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_mux_nto1_reg.sv
// Directed test of mux_nto1_reg (N=4, WIDTH=32) with hand-computed results.
module tb_mux_nto1_reg;

  localparam int WIDTH = 32;
  localparam int N     = 4;
  localparam int SEL_W = 2;

  logic                    clk;
  logic                    rst;
  logic [N-1:0][WIDTH-1:0] in_data;
  logic [N-1:0]            in_valid;
  logic [N-1:0]            in_ready;
  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic                    flush;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_src;
  logic                    out_valid;
  logic                    out_ready;

  int n_checks = 0;
  int n_errors = 0;

  mux_nto1_reg #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .flush     (flush),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end else begin
      $display("ok   %s: %0h", tag, observed);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = '0;
    mode      = 1'b0;
    sel       = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_data",  64'(out_data),  64'd0);
    check("reset_src",   64'(out_src),   64'd0);
    rst = 1'b0;
    tick();

    // Explicit select of channel 2
    in_data[2] = 32'hF0F0F0F0;
    in_valid   = 4'b0100;
    sel        = 2'd2;
    out_ready  = 1'b1;
    #1;
    check("sel2_ready", 64'(in_ready), 64'h4);
    tick();
    check("sel2_data",  64'(out_data),  64'hF0F0F0F0);
    check("sel2_src",   64'(out_src),   64'd2);
    check("sel2_valid", 64'(out_valid), 64'd1);
    in_valid = '0;
    tick();
    check("sel2_drain", 64'(out_valid), 64'd0);

    // Stall: fill with channel 3, then hold out_ready low
    in_data[3] = 32'h33333333;
    in_valid   = 4'b1000;
    sel        = 2'd3;
    out_ready  = 1'b0;
    tick();
    check("stall_fill", 64'(out_data), 64'h33333333);
    in_data[1] = 32'h80000001;
    in_valid   = 4'b0010;
    sel        = 2'd1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("stall_ready_%0d", c), 64'(in_ready), 64'h0);
      tick();
      check($sformatf("stall_data_%0d", c),  64'(out_data),  64'h33333333);
      check($sformatf("stall_valid_%0d", c), 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    #1;
    check("release_ready", 64'(in_ready), 64'h2);
    tick();
    check("release_data", 64'(out_data), 64'h80000001);
    check("release_src",  64'(out_src),  64'd1);
    in_valid = '0;
    tick();
    check("release_drain", 64'(out_valid), 64'd0);

    // Round-robin, all channels valid, no bubbles
    for (int i = 0; i < N; i++) in_data[i] = 32'hA0000000 + 32'(i);
    mode     = 1'b1;
    in_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("rr_ready_%0d", k), 64'(in_ready), 64'(4'b0001 << (k % 4)));
      tick();
      check($sformatf("rr_src_%0d", k),   64'(out_src),   64'(k % 4));
      check($sformatf("rr_data_%0d", k),  64'(out_data),  64'(32'hA0000000 + 32'(k % 4)));
      check($sformatf("rr_valid_%0d", k), 64'(out_valid), 64'd1);
    end
    // ptr is now 1; a grant on channel 2 moves it to 3
    in_valid = 4'b0100;
    tick();
    check("rr_to3_src", 64'(out_src), 64'd2);
    in_valid = 4'b0001;
    #1;
    check("wrap_ready", 64'(in_ready), 64'h1);
    tick();
    check("wrap_src", 64'(out_src), 64'd0);
    in_valid = 4'b1111;
    #1;
    check("wrap_ptr1", 64'(in_ready), 64'h2);

    // Flush with a pending request on channel 1
    in_valid = 4'b0010;
    flush    = 1'b1;
    #1;
    check("flush_ready", 64'(in_ready), 64'h0);
    tick();
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_src",   64'(out_src),   64'd0);
    flush    = 1'b0;
    in_valid = 4'b1111;
    #1;
    check("flush_ptr_kept", 64'(in_ready), 64'h2);
    mode = 1'b0;
    sel  = 2'd3;
    #1;
    check("mode_switch_ready", 64'(in_ready), 64'h8);

    // Reset in the middle of traffic
    mode = 1'b1;
    tick();
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    check("pre_rst_src",   64'(out_src),   64'd1);
    rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_data",  64'(out_data),  64'd0);
    tick();
    check("rst_no_xfer", 64'(out_valid), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_ptr0", 64'(in_ready), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
